// File: rtl/rlwe_instr_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rlwe_instr_loader_if                                          |
// | Description : Host descriptor, source-memory read and FIFO push signals     |
// |               of the RLWE instruction loader, with loader/environment views.|
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
interface rlwe_instr_loader_if #(
    parameter int WIDTH     = 32,
    parameter int AWIDTH    = 32,
    parameter int MAX_WORDS = 262144,
    parameter int CNT_WIDTH = $clog2(MAX_WORDS + 1)
);
    // Host descriptor and status
    logic                 start;
    logic [AWIDTH-1:0]    base_addr;
    logic [CNT_WIDTH-1:0] word_cnt;
    logic                 busy;
    logic                 done;
    logic                 err;
    // Source memory read port
    logic                 mem_req;
    logic                 mem_req_ack;
    logic [AWIDTH-1:0]    mem_addr;
    logic [WIDTH-1:0]     mem_rdata;
    logic [1:0]           mem_resp;
    // Instruction FIFO write side
    logic                 full;
    logic                 almost_full;
    logic                 enqueue_en;
    logic [WIDTH-1:0]     value_i;
    logic [WIDTH-1:0]     checksum;

    modport master (
        input  start, base_addr, word_cnt,
        input  mem_req_ack, mem_rdata, mem_resp,
        input  full, almost_full,
        output busy, done, err,
        output mem_req, mem_addr,
        output enqueue_en, value_i, checksum
    );

    modport slave (
        output start, base_addr, word_cnt,
        output mem_req_ack, mem_rdata, mem_resp,
        output full, almost_full,
        input  busy, done, err,
        input  mem_req, mem_addr,
        input  enqueue_en, value_i, checksum
    );
endinterface
`default_nettype wire

// File: rtl/rlwe_instr_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rlwe_instr_loader                                             |
// | Description : Fetches a block of program words from source memory and       |
// |               pushes them in address order into the RLWE instruction FIFO.  |
// |               Optional running checksum: define RLWE_LOADER_CHECKSUM_EN.    |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module rlwe_instr_loader #(
    parameter int WIDTH     = 32,
    parameter int AWIDTH    = 32,
    parameter int MAX_WORDS = 262144,
    parameter int CNT_WIDTH = $clog2(MAX_WORDS + 1)
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    rlwe_instr_loader_if.master     bus
);

    localparam logic [1:0] RESP_IDLE   = 2'b00;
    localparam logic [1:0] RESP_RDY_OK = 2'b01;
    localparam logic [1:0] RESP_RDY_ER = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_REQ       = 3'd1,
        S_WAIT_RESP = 3'd2,
        S_PUSH      = 3'd3,
        S_FINISH    = 3'd4
    } state_e;

    state_e               state_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 err_q;
    logic                 mem_req_q;
    logic [AWIDTH-1:0]    addr_q;
    logic [CNT_WIDTH-1:0] remaining_q;
    logic [WIDTH-1:0]     value_q;
    logic                 room_w;
    logic                 enq_w;

    // A request is only raised when the FIFO can absorb the word it returns.
    assign room_w = !bus.almost_full && !bus.full;
    assign enq_w  = (state_q == S_PUSH) && !bus.full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            addr_q      <= '0;
            remaining_q <= '0;
            value_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        err_q  <= 1'b0;
                        busy_q <= 1'b1;
                        if (bus.base_addr[1:0] != 2'b00) begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= S_FINISH;
                        end else if (bus.word_cnt == '0) begin
                            done_q  <= 1'b1;
                            state_q <= S_FINISH;
                        end else begin
                            addr_q      <= bus.base_addr;
                            remaining_q <= bus.word_cnt;
                            mem_req_q   <= room_w;
                            state_q     <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    // Once raised, the request holds until the memory takes it.
                    if (mem_req_q) begin
                        if (bus.mem_req_ack) begin
                            mem_req_q <= 1'b0;
                            state_q   <= S_WAIT_RESP;
                        end
                    end else begin
                        mem_req_q <= room_w;
                    end
                end
                S_WAIT_RESP: begin
                    case (bus.mem_resp)
                        RESP_RDY_OK: begin
                            value_q <= bus.mem_rdata;
                            state_q <= S_PUSH;
                        end
                        RESP_RDY_ER: begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= S_FINISH;
                        end
                        RESP_IDLE: state_q <= S_WAIT_RESP;
                        default:   state_q <= S_WAIT_RESP;
                    endcase
                end
                S_PUSH: begin
                    if (enq_w) begin
                        addr_q      <= addr_q + AWIDTH'(4);
                        remaining_q <= remaining_q - CNT_WIDTH'(1);
                        if (remaining_q == CNT_WIDTH'(1)) begin
                            done_q  <= 1'b1;
                            state_q <= S_FINISH;
                        end else begin
                            mem_req_q <= room_w;
                            state_q   <= S_REQ;
                        end
                    end
                end
                S_FINISH: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q    <= 1'b0;
                    mem_req_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

`ifdef RLWE_LOADER_CHECKSUM_EN
    logic [WIDTH-1:0] checksum_q;
    logic [WIDTH-1:0] checksum_d;

    assign checksum_d = checksum_q + value_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_q <= '0;
        end else if ((state_q == S_IDLE) && bus.start) begin
            checksum_q <= '0;
        end else if (enq_w) begin
            checksum_q <= checksum_d;
        end
    end

    assign bus.checksum = checksum_q;
`else
    assign bus.checksum = '0;
`endif

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_addr   = addr_q;
    assign bus.enqueue_en = enq_w;
    assign bus.value_i    = value_q;

endmodule
`default_nettype wire

// File: tb/tb_rlwe_instr_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_rlwe_instr_loader                                          |
// | Description : Directed scoreboard bench for rlwe_instr_loader.              |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_rlwe_instr_loader;

    localparam logic [1:0] RESP_IDLE   = 2'b00;
    localparam logic [1:0] RESP_RDY_OK = 2'b01;
    localparam logic [1:0] RESP_RDY_ER = 2'b10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    rlwe_instr_loader_if #(.WIDTH(32), .AWIDTH(32), .MAX_WORDS(262144)) bus ();

    rlwe_instr_loader #(.WIDTH(32), .AWIDTH(32), .MAX_WORDS(262144)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int req_cnt  = 0;
    int enq_cnt  = 0;
    int done_cnt = 0;

    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic        pend      = 1'b0;
    logic [31:0] pend_addr = '0;
    logic        resp_hold = 1'b0;
    logic [31:0] err_addr  = 32'h1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA0 + ((a - 32'h1000) >> 2);
    endfunction

    // Memory responder and output monitor: drive at negedge+1, sample at negedge+2.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            bus.mem_req_ack = bus.mem_req;
            if (pend && !resp_hold) begin
                bus.mem_resp  = (pend_addr == err_addr) ? RESP_RDY_ER : RESP_RDY_OK;
                bus.mem_rdata = mem_word(pend_addr);
                pend = 1'b0;
            end else begin
                bus.mem_resp  = RESP_IDLE;
                bus.mem_rdata = '0;
            end
            #1;
            if (bus.mem_req && bus.mem_req_ack) begin
                req_cnt++;
                pend      = 1'b1;
                pend_addr = bus.mem_addr;
                if (exp_addr.size() == 0) check("req_unexpected", 1, 0);
                else check("req_addr", bus.mem_addr, exp_addr.pop_front());
            end
            if (bus.enqueue_en) begin
                enq_cnt++;
                if (exp_data.size() == 0) check("enq_unexpected", 1, 0);
                else check("enq_data", bus.value_i, exp_data.pop_front());
            end
            if (bus.full) check("enq_while_full", bus.enqueue_en, 0);
            if (bus.done) begin
                done_cnt++;
                check("busy_with_done", bus.busy, 1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic expect_xfer(input logic [31:0] base, input int n_req, input int n_data);
        for (int i = 0; i < n_req; i++) exp_addr.push_back(base + 32'(4 * i));
        for (int i = 0; i < n_data; i++) exp_data.push_back(mem_word(base + 32'(4 * i)));
    endtask

    task automatic pulse_start(input logic [31:0] base, input logic [18:0] cnt);
        @(negedge clk);
        bus.base_addr = base;
        bus.word_cnt  = cnt;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
    endtask

    // Waits for a done pulse beyond d0, then checks that busy and done fall together.
    task automatic wait_done(input string tag, input int d0, input int max_cycles);
        bit seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            #3;
            if (done_cnt > d0) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_done_seen"}, seen, 1);
        @(negedge clk);
        #3;
        check({tag, "_busy_after"}, bus.busy, 0);
        check({tag, "_done_one_cycle"}, bus.done, 0);
    endtask

    task automatic wait_reqs(input int target, input int max_cycles);
        bit seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            #3;
            if (req_cnt >= target) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("req_wait", seen, 1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_err"}, bus.err, 0);
        check({tag, "_mem_req"}, bus.mem_req, 0);
        check({tag, "_mem_addr"}, bus.mem_addr, 0);
        check({tag, "_enq"}, bus.enqueue_en, 0);
        check({tag, "_value"}, bus.value_i, 0);
        check({tag, "_checksum"}, bus.checksum, 0);
    endtask

    initial begin
        int d0, e0, r0;
        bit stable;
        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.word_cnt = '0;
        bus.mem_req_ack = 1'b0;
        bus.mem_rdata = '0;
        bus.mem_resp = RESP_IDLE;
        bus.full = 1'b0;
        bus.almost_full = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #3;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: basic four-word transfer
        d0 = done_cnt; e0 = enq_cnt;
        expect_xfer(32'h1000, 4, 4);
        pulse_start(32'h1000, 19'd4);
        wait_done("basic", d0, 40);
        check("basic_enq_count", enq_cnt - e0, 4);
        check("basic_err", bus.err, 0);
`ifdef RLWE_LOADER_CHECKSUM_EN
        check("basic_checksum", bus.checksum, 32'h286);
`endif

        // 2: FIFO full for 10 cycles while the second word waits to be pushed
        d0 = done_cnt; e0 = enq_cnt; r0 = req_cnt;
        expect_xfer(32'h2000, 4, 4);
        pulse_start(32'h2000, 19'd4);
        wait_reqs(r0 + 2, 40);
        @(negedge clk);
        bus.full = 1'b1;
        stable = 1'b1;
        for (int j = 0; j < 10; j++) begin
            #3;
            if (j > 0 && bus.value_i !== mem_word(32'h2004)) stable = 1'b0;
            @(negedge clk);
        end
        check("full_value_stable", stable, 1);
        check("full_enq_held", enq_cnt - e0, 1);
        bus.full = 1'b0;
        #3;
        check("full_release_enq", bus.enqueue_en, 1);
        check("full_release_value", bus.value_i, mem_word(32'h2004));
        @(negedge clk);
        wait_done("full", d0, 40);
        check("full_enq_count", enq_cnt - e0, 4);

        // 3: almost_full blocks the request; it rises the cycle after release
        d0 = done_cnt;
        expect_xfer(32'h6000, 2, 2);
        bus.almost_full = 1'b1;
        pulse_start(32'h6000, 19'd2);
        for (int j = 0; j < 4; j++) begin
            #3;
            check("af_req_blocked", bus.mem_req, 0);
            @(negedge clk);
        end
        bus.almost_full = 1'b0;
        #3;
        check("af_req_same_cycle", bus.mem_req, 0);
        @(negedge clk);
        #3;
        check("af_req_rises", bus.mem_req, 1);
        check("af_addr_kept", bus.mem_addr, 32'h6000);
        @(negedge clk);
        wait_done("af", d0, 40);

        // 4: RDY_ER on second read, then a valid start clears err
        d0 = done_cnt; e0 = enq_cnt;
        err_addr = 32'h3004;
        expect_xfer(32'h3000, 2, 1);
        pulse_start(32'h3000, 19'd4);
        wait_done("memerr", d0, 40);
        check("memerr_enq_count", enq_cnt - e0, 1);
        check("memerr_err", bus.err, 1);
        err_addr = 32'h1;
        d0 = done_cnt;
        expect_xfer(32'h4000, 1, 1);
        pulse_start(32'h4000, 19'd1);
        #3;
        check("restart_err_cleared", bus.err, 0);
        check("restart_busy", bus.busy, 1);
        @(negedge clk);
        wait_done("restart", d0, 20);

        // 5a: zero word count
        d0 = done_cnt; r0 = req_cnt;
        pulse_start(32'h1000, 19'd0);
        wait_done("zero", d0, 2);
        check("zero_no_req", req_cnt - r0, 0);
        check("zero_err", bus.err, 0);

        // 5b: misaligned base
        d0 = done_cnt; r0 = req_cnt;
        pulse_start(32'h1002, 19'd3);
        wait_done("misalign", d0, 2);
        check("misalign_no_req", req_cnt - r0, 0);
        check("misalign_err", bus.err, 1);

        // 5c: address wraps to zero
        d0 = done_cnt; e0 = enq_cnt;
        expect_xfer(32'hFFFF_FFFC, 2, 2);
        pulse_start(32'hFFFF_FFFC, 19'd2);
        wait_done("wrap", d0, 30);
        check("wrap_enq_count", enq_cnt - e0, 2);
        check("wrap_err", bus.err, 0);

        // 6: reset during WAIT_RESP
        d0 = done_cnt; e0 = enq_cnt; r0 = req_cnt;
        resp_hold = 1'b1;
        expect_xfer(32'h7000, 1, 0);
        pulse_start(32'h7000, 19'd3);
        wait_reqs(r0 + 1, 20);
        @(negedge clk);
        rst_n = 1'b0;
        #3;
        check_reset_state("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        resp_hold = 1'b0;
        repeat (8) @(negedge clk);
        #3;
        check("midrst_no_enq", enq_cnt - e0, 0);
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_no_new_req", req_cnt - r0, 1);
        check("midrst_busy", bus.busy, 0);

        check("sb_addr_empty", exp_addr.size(), 0);
        check("sb_data_empty", exp_data.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
